// File: rtl/sec_decoder_location_52b_if.sv
// Receive-side bundle for the AN-code decoder: code word in, data word and done flag out.
interface sec_decoder_location_52b_if #(
   parameter int W_BITS = 61,
   parameter int N_BITS = 53
);
   logic [W_BITS-1:0] W;
   logic [N_BITS-1:0] N;
   logic              found;

   modport master (output W, input N, input found);
   modport slave  (input W, output N, output found);
endinterface

// File: rtl/sec_decoder_location_52b.sv
// AN-code (A=131) single-error corrector: residue, serial +-2^i search, correct, divide.
// Latency 3 edges clean, 4+i edges for error at bit i, 64 on failure; no backpressure, a new W restarts the decode.
module sec_decoder_location_52b #(
   parameter int W_BITS = 61,
   parameter int N_BITS = 53,
   parameter int A      = 131
) (
   input logic                 clk,
   input logic                 rst_n,
   sec_decoder_location_52b_if.slave bus
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SYN    = 3'd1;
   localparam logic [2:0] SEARCH = 3'd2;
   localparam logic [2:0] DIV    = 3'd3;
   localparam logic [2:0] FAIL   = 3'd4;
   localparam logic [2:0] DONE   = 3'd5;

   localparam logic [8:0] A9      = 9'(A);
   localparam logic [7:0] A8      = 8'(A);
   localparam logic [5:0] LAST_IX = 6'(W_BITS - 1);

   logic [2:0]        state;
   logic              start_pending;
   logic [W_BITS-1:0] w_reg;
   logic [7:0]        s;
   logic [5:0]        idx;
   logic [7:0]        p;
   logic [W_BITS:0]   c;
   logic [N_BITS-1:0] n_q;
   logic              found_q;

   logic [7:0]        res_now;
   logic [7:0]        p_next;
   logic [8:0]        p_dbl;
   logic [W_BITS:0]   w_ext;
   logic [W_BITS:0]   pow;
   logic              restart;

   // Bit-serial long division by A, MSB first; remainder stays below A so 8 bits suffice.
   function automatic logic [7:0] mod_a(input logic [W_BITS-1:0] x);
      logic [7:0] r;
      logic [8:0] acc;
      r   = '0;
      acc = '0;
      for (int b = W_BITS - 1; b >= 0; b--) begin
         acc = {r, x[b]};
         if (acc >= A9) acc = acc - A9;
         r = acc[7:0];
      end
      return r;
   endfunction

   // Same division, keeping the low N_BITS quotient bits as they shift through.
   function automatic logic [N_BITS-1:0] div_a(input logic [W_BITS:0] x);
      logic [7:0]        r;
      logic [8:0]        acc;
      logic [N_BITS-1:0] q;
      logic              hit;
      r   = '0;
      acc = '0;
      q   = '0;
      hit = 1'b0;
      for (int b = W_BITS; b >= 0; b--) begin
         acc = {r, x[b]};
         hit = (acc >= A9);
         if (hit) acc = acc - A9;
         r = acc[7:0];
         q = {q[N_BITS-2:0], hit};
      end
      return q;
   endfunction

   always_comb begin
      res_now = mod_a(w_reg);
      w_ext   = {1'b0, w_reg};
      pow     = {{W_BITS{1'b0}}, 1'b1} << idx;
      p_dbl   = {p, 1'b0};
      p_next  = (p_dbl >= A9) ? 8'(p_dbl - A9) : p_dbl[7:0];
      restart = start_pending || (bus.W != w_reg);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         start_pending <= 1'b1;
         w_reg         <= '0;
         s             <= '0;
         idx           <= '0;
         p             <= '0;
         c             <= '0;
         n_q           <= '0;
         found_q       <= 1'b0;
      end else if (restart) begin
         // A new word wins over any step in flight, including the one that would raise found.
         w_reg         <= bus.W;
         found_q       <= 1'b0;
         start_pending <= 1'b0;
         state         <= SYN;
      end else begin
         case (state)
            SYN: begin
               s <= res_now;
               if (res_now == 8'd0) begin
                  c     <= w_ext;
                  state <= DIV;
               end else begin
                  idx   <= '0;
                  p     <= 8'd1;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (s == p) begin
                  c     <= w_ext - pow;
                  state <= DIV;
               end else if (s == A8 - p) begin
                  c     <= w_ext + pow;
                  state <= DIV;
               end else if (idx == LAST_IX) begin
                  state <= FAIL;
               end else begin
                  idx <= idx + 6'd1;
                  p   <= p_next;
               end
            end
            DIV: begin
               n_q     <= div_a(c);
               found_q <= 1'b1;
               state   <= DONE;
            end
            FAIL: begin
               n_q     <= '0;
               found_q <= 1'b1;
               state   <= DONE;
            end
            IDLE, DONE: state <= state;
            default:    state <= IDLE;
         endcase
      end
   end

   assign bus.N     = n_q;
   assign bus.found = found_q;
endmodule

// File: tb/tb_sec_decoder_location_52b.sv
// Directed bench for the A=131 decoder: vector table plus abort, same-edge restart and reset corners.
module tb_sec_decoder_location_52b;
   logic clk;
   logic rst_n;

   sec_decoder_location_52b_if bus();

   sec_decoder_location_52b dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [60:0] w;
      logic [52:0] n;
      int          edges;
      string       name;
   } vec_t;

   localparam logic [60:0] W0    = 61'd589971551185534845;
   localparam logic [52:0] NMAX  = 53'd4503599627370495;

   vec_t vecs [8];
   int   checks;
   int   errors;
   int   edges;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Counts capture-relative edges until found is seen high at the following negedge.
   task automatic wait_found(output int n_edges);
      n_edges = 0;
      do begin
         @(posedge clk);
         n_edges++;
         @(negedge clk);
      end while (!bus.found && n_edges < 100);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = '{W0 + 61'd1,                  NMAX,        4,  "p2_0"};
      vecs[1] = '{W0 - 61'd32,                 NMAX,        9,  "m2_5"};
      vecs[2] = '{61'd1166432303488958333,     NMAX,        63, "p2_59"};
      vecs[3] = '{W0 + 61'd90,                 53'd0,       64, "uncorrectable"};
      vecs[4] = '{61'd1616171,                 53'd12345,   14, "m2_10"};
      vecs[5] = '{61'd1152921504606847107,     53'd1,       64, "p2_60"};
      vecs[6] = '{W0,                          NMAX,        3,  "clean_max"};
      vecs[7] = '{61'd1617195,                 53'd12345,   3,  "clean_small"};

      rst_n  = 1'b0;
      bus.W  = W0;
      #2;
      check("reset_n", 64'(bus.N), 64'd0);
      check("reset_found", 64'(bus.found), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;
      wait_found(edges);
      check("first_latency", 64'(edges), 64'd3);
      check("first_n", 64'(bus.N), 64'(NMAX));
      check("first_n52", 64'(bus.N[52]), 64'd0);

      for (int k = 0; k < 8; k++) begin
         bus.W = vecs[k].w;
         wait_found(edges);
         check({vecs[k].name, "_latency"}, 64'(edges), 64'(vecs[k].edges));
         check({vecs[k].name, "_n"}, 64'(bus.N), 64'(vecs[k].n));
      end

      // Abort while searching for the -2^5 error, restart on the +2^0 word.
      bus.W = W0 - 61'd32;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("abort_found_low", 64'(bus.found), 64'd0);
      bus.W = W0 + 61'd1;
      wait_found(edges);
      check("abort_latency", 64'(edges), 64'd4);
      check("abort_n", 64'(bus.N), 64'(NMAX));

      // Change W right before the edge that would raise found.
      bus.W = W0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.W = 61'd1617195;
      @(posedge clk);
      @(negedge clk);
      check("same_edge_found_low", 64'(bus.found), 64'd0);
      wait_found(edges);
      check("same_edge_latency", 64'(edges), 64'd2);
      check("same_edge_n", 64'(bus.N), 64'd12345);

      // Asynchronous reset in the middle of a long search.
      bus.W = 61'd1166432303488958333;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("pre_reset_found", 64'(bus.found), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_n", 64'(bus.N), 64'd0);
      check("async_reset_found", 64'(bus.found), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_found(edges);
      check("post_reset_latency", 64'(edges), 64'd63);
      check("post_reset_n", 64'(bus.N), 64'(NMAX));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
